// File: rtl/piano_pkg.sv
// Shared constants for the piano controller front end: scan codes,
// note index width and the PS/2 frame receiver state encoding.
package piano_pkg;
   localparam logic [7:0] STOP_CODE = 8'd99;
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_A      = 8'h1C;
   localparam logic [7:0] SC_S      = 8'h1B;
   localparam logic [7:0] SC_D      = 8'h23;
   localparam logic [7:0] SC_F      = 8'h2B;
   localparam logic [7:0] SC_G      = 8'h34;
   localparam logic [7:0] SC_H      = 8'h33;
   localparam logic [7:0] SC_J      = 8'h3B;
   localparam logic [7:0] SC_K      = 8'h42;
   localparam int         NOTE_W    = 4;

   typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the device pins, samples data on falling
// clock edges, checks start/parity/stop and aborts stalled frames.
module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);
   import piano_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // clk_sync[1:0] is the 2-FF synchroniser, clk_sync[2] the previous sample
   logic [2:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          fall, bit_in, timeout, frame_ok;
   rx_state_t     state, state_nxt;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] to_cnt;

   assign fall     = clk_sync[2] & ~clk_sync[1];
   assign bit_in   = dat_sync[1];
   assign timeout  = (to_cnt == TW'(TIMEOUT_CYCLES));
   assign frame_ok = (^shreg[8:0]) & shreg[9];
   assign rx_byte  = shreg[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync <= 3'b111;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[1:0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_nxt;
   end

   // Bits enter at the top so after ten shifts: [7:0] data, [8] parity, [9] stop
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (state == RX_IDLE) begin
         bit_cnt <= '0;
      end else if (state == RX_SHIFT && fall) begin
         shreg   <= {bit_in, shreg[9:1]};
         bit_cnt <= bit_cnt + 4'd1;
      end
   end

   // Saturates at TIMEOUT_CYCLES so a stalled line never wraps back to zero
   always_ff @(posedge clk) begin
      if (rst || fall)                     to_cnt <= '0;
      else if (state == RX_SHIFT && !timeout) to_cnt <= to_cnt + 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:  if (fall && !bit_in) state_nxt = RX_SHIFT;
         RX_SHIFT: begin
            if (timeout)                    state_nxt = RX_IDLE;
            else if (fall && bit_cnt == 4'd9) state_nxt = RX_CHECK;
         end
         RX_CHECK: state_nxt = RX_IDLE;
         default:  state_nxt = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_valid = 1'b0;
      rx_err   = 1'b0;
      case (state)
         RX_IDLE:  rx_err = fall & bit_in;
         RX_SHIFT: rx_err = timeout;
         RX_CHECK: begin
            rx_valid = frame_ok;
            rx_err   = ~frame_ok;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/ps2_note_decoder.sv
// Turns PS/2 make/break scan codes for the home-row keys into note indices,
// emitting STOP_CODE when the currently held note is released.
module ps2_note_decoder #(
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] STOP_CODE      = piano_pkg::STOP_CODE
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iPs2_Clk,
   input  logic       iPs2_Dat,
   output logic [7:0] oPs2_Data,
   output logic       oValid,
   output logic       oFrameErr
);
   import piano_pkg::*;

   logic [7:0]        rx_byte;
   logic              rx_valid, rx_err;
   logic              brk, ext;
   logic [NOTE_W-1:0] note_idx, held;

   ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk      (iClk),
      .rst      (iReset),
      .ps2_clk  (iPs2_Clk),
      .ps2_dat  (iPs2_Dat),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   // Zero doubles as "unmapped" and as "no note held"
   always_comb begin
      note_idx = '0;
      case (rx_byte)
         SC_A: note_idx = 4'd1;
         SC_S: note_idx = 4'd2;
         SC_D: note_idx = 4'd3;
         SC_F: note_idx = 4'd4;
         SC_G: note_idx = 4'd5;
         SC_H: note_idx = 4'd6;
         SC_J: note_idx = 4'd7;
         SC_K: note_idx = 4'd8;
         default: note_idx = '0;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         oPs2_Data <= STOP_CODE;
         oValid    <= 1'b0;
         oFrameErr <= 1'b0;
         brk       <= 1'b0;
         ext       <= 1'b0;
         held      <= '0;
      end else begin
         oValid    <= 1'b0;
         oFrameErr <= rx_err;
         if (rx_valid) begin
            if (rx_byte == SC_EXT)        ext <= 1'b1;
            else if (rx_byte == SC_BREAK) brk <= 1'b1;
            else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (!ext && note_idx != '0) begin
                  if (!brk && note_idx != held) begin
                     oPs2_Data <= 8'(note_idx);
                     oValid    <= 1'b1;
                     held      <= note_idx;
                  end else if (brk && note_idx == held) begin
                     oPs2_Data <= STOP_CODE;
                     oValid    <= 1'b1;
                     held      <= '0;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: bit-bangs PS/2 frames and checks the
// decoded codes, pulse counts and stop-edge-to-oValid latency.
module tb_ps2_note_decoder;
   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] data;
   logic       valid, ferr;

   int checks = 0;
   int errors = 0;
   int vcnt = 0;
   int ecnt = 0;

   ps2_note_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .iClk      (clk),
      .iReset    (rst),
      .iPs2_Clk  (ps2_clk),
      .iPs2_Dat  (ps2_dat),
      .oPs2_Data (data),
      .oValid    (valid),
      .oFrameErr (ferr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) vcnt++;
      if (ferr)  ecnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One PS/2 bit; optionally measure stop-edge-to-oValid latency
   task automatic ps2_bit(input logic b, input bit lat);
      @(negedge clk);
      ps2_dat = b;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (lat) begin
         repeat (3) @(posedge clk);
         #1 check("lat_early", int'(valid), 0);
         @(posedge clk);
         #1 check("lat_hit", int'(valid), 1);
      end
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip,
                             input logic stop, input bit lat, input int nbits);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(bits[i], lat && i == 10);
      repeat (10) @(negedge clk);
      ps2_dat = 1'b1;
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 1'b0, 11);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_data", int'(data), 99);
      check("rst_valid", int'(valid), 0);
      check("rst_err", int'(ferr), 0);
      rst = 1'b0;

      repeat (1000) @(negedge clk);
      check("idle_data", int'(data), 99);
      check("idle_vcnt", vcnt, 0);
      check("idle_ecnt", ecnt, 0);

      send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11);
      check("a_make", int'(data), 1);
      check("a_vcnt", vcnt, 1);

      good(8'h1C); good(8'h1C); good(8'h1C);
      check("repeat_vcnt", vcnt, 1);
      check("repeat_data", int'(data), 1);
      good(8'hF0); good(8'h1C);
      check("a_break", int'(data), 99);
      check("a_break_vcnt", vcnt, 2);

      good(8'h1C);
      check("a_make2", int'(data), 1);
      good(8'h23);
      check("d_make", int'(data), 3);
      good(8'hF0); good(8'h1C);
      check("a_rel_nonheld", int'(data), 3);
      check("a_rel_vcnt", vcnt, 4);

      send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 11);
      check("par_err", ecnt, 1);
      check("par_data", int'(data), 3);
      send_frame(8'h23, 1'b0, 1'b0, 1'b0, 11);
      check("stop_err", ecnt, 2);
      check("stop_data", int'(data), 3);
      ps2_bit(1'b1, 1'b0);
      repeat (10) @(negedge clk);
      check("start_err", ecnt, 3);
      good(8'hE0); good(8'h1C);
      check("ext_vcnt", vcnt, 4);
      check("ext_data", int'(data), 3);
      good(8'hF0); good(8'h23);
      check("d_break", int'(data), 99);
      check("d_break_vcnt", vcnt, 5);

      send_frame(8'h42, 1'b0, 1'b1, 1'b0, 5);
      repeat (TO + 100) @(negedge clk);
      check("timeout_err", ecnt, 4);
      good(8'h42);
      check("k_make", int'(data), 8);
      check("k_vcnt", vcnt, 6);

      send_frame(8'h1B, 1'b0, 1'b1, 1'b0, 5);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_data", int'(data), 99);
      good(8'h1C);
      check("post_rst_data", int'(data), 1);
      check("post_rst_vcnt", vcnt, 7);
      check("final_ecnt", ecnt, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_note_decoder.md
Name: ps2_note_decoder

Overview:
- Upstream stage of the piano controller.
- Receives raw PS/2 keyboard frames (device-driven clock and data), checks each frame and tracks make/break prefixes.
- Maps the home-row keys to note indices and produces the registered decoded key code that the controller consumes on its iPs2_Data input.
- Code STOP_CODE (99) means "stop playing the note"; it is emitted when the held key is released.

Parameters:
- TIMEOUT_CYCLES, 100000, iClk cycles without a PS/2 falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).
- STOP_CODE, 99, code emitted on release of the held note; also the reset value.

Ports:
- iClk  input  1  system clock.
- iReset  input  1  synchronous, active-high reset.
- iPs2_Clk  input  1  raw PS/2 clock pin, asynchronous.
- iPs2_Dat  input  1  raw PS/2 data pin, asynchronous.
- oPs2_Data  output  8  decoded key code: 1..8 = note index; STOP_CODE = silence. Registered and held between updates.
- oValid  output  1  single-cycle pulse in the cycle oPs2_Data takes a new value.
- oFrameErr  output  1  single-cycle pulse on a start, parity, stop or timeout error.

Behaviour:
- Reset (iReset high at a rising iClk edge): oPs2_Data = STOP_CODE, oValid = 0, oFrameErr = 0. All FSMs go idle, the break and extended flags clear, and held note = none. Reset mid-frame discards the partial frame.
- Input conditioning:
  - iPs2_Clk and iPs2_Dat each pass through a 2-FF synchroniser.
  - A falling edge is defined as synchronised clk previous = 1, current = 0.
  - Data is sampled only on that edge.
- Frame receiver FSM, states RX_IDLE, RX_SHIFT, RX_CHECK:
  - RX_IDLE: on a falling edge with data = 0 (start bit), go to RX_SHIFT with bit count = 0. A start bit of 1 pulses oFrameErr and stays in RX_IDLE.
  - RX_SHIFT: shift 10 bits on falling edges: 8 data bits LSB first, then odd parity, then stop. After the 10th bit, go to RX_CHECK.
  - RX_CHECK (1 cycle): frame is valid iff parity over data+parity bit is odd and stop = 1. A valid byte goes to the code stage; an invalid one pulses oFrameErr. Return to RX_IDLE.
  - Timeout: a counter clears on every falling edge and counts in RX_SHIFT. At TIMEOUT_CYCLES it pulses oFrameErr and returns to RX_IDLE. The counter saturates and never wraps.
- Code stage, processing one byte at a time:
  - 0xE0: set the extended flag; no output.
  - 0xF0: set the break flag; no output.
  - Any other byte is a key code:
    - If the extended flag is set, the key is ignored.
    - Otherwise the key maps to note idx: 0x1C→1, 0x1B→2, 0x23→3, 0x2B→4, 0x34→5, 0x33→6, 0x3B→7, 0x42→8; all other codes are unmapped.
    - After the key code is handled, both flags clear.
  - Make (break flag clear), mapped key:
    - If idx ≠ held note: oPs2_Data ← idx, oValid pulse, held ← idx.
    - If idx = held (typematic repeat): no output.
  - Break (break flag set), mapped key:
    - If idx = held: oPs2_Data ← STOP_CODE, oValid pulse, held ← none.
    - Release of a non-held key: no output.
  - Unmapped key: no output.
- Latency: oValid is high exactly 4 iClk cycles after the stop-bit falling edge appears on iPs2_Clk (2 sync stages, edge/RX_CHECK, output register).
- Simultaneous events: the code stage accepts at most one byte per RX_CHECK, so there are no collisions. A frame error leaves the flags and held note unchanged.

Decomposition:
- Shared package piano_pkg: STOP_CODE, scan-code constants (SC_BREAK = 0xF0, SC_EXT = 0xE0, SC_A..SC_K), note-index width, RX state enum.
- Sub-module ps2_frame_rx: synchroniser, edge detector, RX FSM and timeout. Outputs are a byte plus byte-valid and error pulses.
- The top level holds the code stage and the mapping case statement.

Test Plan:
- Reset, then idle pins high for 1000 cycles -> oPs2_Data = 99, oValid and oFrameErr never pulse.
- Frame 0x1C (A make), good parity -> one oValid pulse 4 cycles after the stop edge; oPs2_Data = 1.
- 0x1C repeated 3x, then 0xF0, 0x1C -> no oValid on the repeats; single oValid with oPs2_Data = 99 after the break.
- Make 0x1C, then make 0x23, then 0xF0 0x1C -> outputs 1, then 3; the release of A produces no output and oPs2_Data stays 3.
- Frame 0x1C with even parity; separately, a frame with stop = 0 -> oFrameErr pulse each time, oPs2_Data unchanged. Then 0xE0, 0x1C -> no output.
- Abort after 5 bits and wait TIMEOUT_CYCLES -> one oFrameErr pulse. A following good 0x42 frame -> oPs2_Data = 8. Assert iReset mid-frame -> oPs2_Data = 99 and the next good frame decodes correctly.
